// File: rtl/display7_scan.sv
// display7_scan: time-multiplexed 7-segment driver.
// Latches a packed hex word on request, decodes the full 0-F set and scans
// one digit per slot. It provides blanking, decimal points, leading-zero
// suppression and dead time between slots to stop ghosting.
module display7_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 100000,
    parameter int DEAD           = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic                  iLoad,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic                  iLzs,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int CW = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
    localparam int IW = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1;

    // Shadow copy of the display request
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lzs;

    // Scan position
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    // Combinational view of the digit in the current slot
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_dark;
    logic [DIGITS-1:0] an_hi;
    logic [DIGITS-1:0] lz_mask;
    logic              zero_run;
    logic [6:0]        seg_hi;
    logic              dp_hi;
    logic [DIGITS-1:0] an_next;

    // Active-high gfedcba pattern for one hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Capture the request into the shadow registers on iLoad
    always_ff @(posedge clk) begin
        // NOTE: these are a handful of flops rather than a RAM, so they take
        // a reset; the display then reads as zero straight after reset.
        if (rst) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lzs   <= 1'b0;
        end else if (iLoad) begin
            sh_data  <= iData;
            sh_dp    <= iDp;
            sh_blank <= iBlank;
            sh_lzs   <= iLzs;
        end
    end

    // Prescaler: advance to the next digit every CLK_DIV cycles
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep cnt and idx updating from the
        // same pre-edge values, independent of statement order.
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Select the current digit and work out whether it is dark
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        an_hi    = '0;
        lz_mask  = '0;
        zero_run = 1'b1;
        // lz_mask[k] is set when nibbles k..DIGITS-1 are all zero
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run & (sh_data[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib  = sh_data[4*k +: 4];
                cur_dp   = sh_dp[k];
                cur_dark = sh_blank[k] | (sh_lzs & (k != 0) & lz_mask[k]);
                an_hi[k] = 1'b1;
            end
        end
        seg_hi  = cur_dark ? 7'h00 : hex_decode(cur_nib);
        dp_hi   = cur_dp & ~cur_dark;
        an_next = (cnt < CW'(DEAD)) ? '0 : an_hi;
    end

    // Register the pins, applying the board polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            oSeg <= {7{SEG_ACTIVE_LOW}};
            oDp  <= SEG_ACTIVE_LOW;
            oAn  <= {DIGITS{AN_ACTIVE_LOW}};
        end else begin
            oSeg <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
            oDp  <= dp_hi ^ SEG_ACTIVE_LOW;
            oAn  <= an_next ^ {DIGITS{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_display7_scan.sv
// tb_display7_scan: scoreboard bench for display7_scan with DIGITS=4,
// CLK_DIV=4, DEAD=1 and active-low segments and anodes.
module tb_display7_scan;

    localparam int DIGITS = 4;
    localparam int CLK_DIV = 4;
    localparam int DEAD = 1;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] iData = '0;
    logic        iLoad = 1'b0;
    logic [3:0]  iDp = '0;
    logic [3:0]  iBlank = '0;
    logic        iLzs = 1'b0;
    logic [6:0]  oSeg;
    logic        oDp;
    logic [3:0]  oAn;

    int n_tests = 0;
    int n_fail = 0;

    display7_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .iData(iData), .iLoad(iLoad), .iDp(iDp),
        .iBlank(iBlank), .iLzs(iLzs), .oSeg(oSeg), .oDp(oDp), .oAn(oAn)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = '0;
    logic        m_lzs = 1'b0;
    int          m_cnt = 0;
    int          m_idx = 0;
    pins_t       sb_q[$];

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: predict the pins for this edge, then advance the model state
    always @(posedge clk) begin
        pins_t e;
        logic  dark;
        logic [3:0] nib;
        if (rst) begin
            e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF};
        end else begin
            nib  = m_data[m_idx*4 +: 4];
            dark = m_blank[m_idx] || (m_lzs && m_idx > 0 && (m_data >> (4*m_idx)) == 16'h0);
            e.seg = dark ? 7'h7F : ~seg_tab[nib];
            e.dp  = !(m_dp[m_idx] && !dark);
            e.an  = (m_cnt < DEAD) ? 4'hF : ~(4'b0001 << m_idx);
        end
        sb_q.push_back(e);
        if (rst) begin
            m_data <= '0; m_dp <= '0; m_blank <= '0; m_lzs <= 1'b0;
            m_cnt <= 0; m_idx <= 0;
        end else begin
            if (iLoad) begin
                m_data <= iData; m_dp <= iDp; m_blank <= iBlank; m_lzs <= iLzs;
            end
            if (m_cnt == CLK_DIV - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx + 1) % DIGITS;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Scoreboard: compare the DUT pins against the oldest prediction
    always @(negedge clk) begin
        pins_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_seg", 32'(oSeg), 32'(e.seg));
            check("sb_dp", 32'(oDp), 32'(e.dp));
            check("sb_an", 32'(oAn), 32'(e.an));
        end
    end

    // Drive one load pulse; caller sits just after a negedge
    task automatic load(input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] bl, input logic lz);
        iData = d; iDp = dp; iBlank = bl; iLzs = lz; iLoad = 1'b1;
        @(negedge clk);
        iLoad = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        // Reset held for three cycles, then the first slot starts dark
        run(3);
        rst = 1'b0;
        @(negedge clk); #2;
        check("rel_an0", 32'(oAn), 32'h F);
        check("rel_seg0", 32'(oSeg), 32'h40);
        @(negedge clk); #2;
        check("rel_an1", 32'(oAn), 32'hE);

        // Plain scan, hex with decimal point, leading-zero suppression
        load(16'h1234, 4'b0000, 4'b0000, 1'b0);  run(20);
        load(16'hABCF, 4'b0100, 4'b0000, 1'b0);  run(20);
        load(16'h0050, 4'b0000, 4'b0000, 1'b1);  run(16);
        load(16'h0000, 4'b0000, 4'b0000, 1'b1);  run(16);
        load(16'h1234, 4'b0000, 4'b0001, 1'b0);  run(17);

        // Mid-slot load shows up one edge after the load edge
        load(16'h8888, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk); #2;
        check("midslot_seg", 32'(oSeg), 32'h00);
        run(8);

        // Reset in the middle of the digit-2 slot
        load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #2;
            if (oAn == 4'hB) found = 1'b1;
        end
        check("find_digit2", 32'(found), 32'h1);
        rst = 1'b1;
        @(negedge clk); #2;
        check("rst_an", 32'(oAn), 32'hF);
        check("rst_seg", 32'(oSeg), 32'h7F);
        rst = 1'b0;
        @(negedge clk); #2;
        check("rst_rel_an0", 32'(oAn), 32'hF);
        @(negedge clk); #2;
        check("rst_rel_an1", 32'(oAn), 32'hE);
        check("rst_rel_seg", 32'(oSeg), 32'h40);
        run(16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
